// File: rtl/ninja_pkg.sv
// Shared definitions for the reflex-game blocks: action codes, FSM states,
// the default tick divider and the answer-window length rule.
package ninja_pkg;

  typedef logic [3:0] action_t;

  localparam action_t ACT_UP    = 4'b0011;
  localparam action_t ACT_DOWN  = 4'b0010;
  localparam action_t ACT_LEFT  = 4'b0001;
  localparam action_t ACT_RIGHT = 4'b0000;

  localparam int unsigned DEF_TICK_DIV = 5_000_000;

  typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} state_t;

  // Window shrinks by step per level and clamps at floor; the subtraction is
  // guarded so a large level never wraps the 8-bit result.
  function automatic logic [7:0] window_len(input logic [2:0] level,
                                            input logic [7:0] base,
                                            input logic [7:0] step,
                                            input logic [7:0] floor);
    logic [10:0] cut;
    cut = 11'(level) * 11'(step);
    if (cut >= 11'(base)) return floor;
    if ((base - cut[7:0]) < floor) return floor;
    return base - cut[7:0];
  endfunction

endpackage

// File: rtl/ninja_action_gen_if.sv
// Prompt/judge bus: game control inputs and prompt/status outputs of the action generator.
interface ninja_action_gen_if;
  logic              start;
  logic [7:0]        wrong_time;
  logic              round_active;
  ninja_pkg::action_t action;
  logic [7:0]        count;
  logic [2:0]        level_num;
  logic              window_start;
  logic              game_over;
  logic              win;

  modport master (
    input  start, wrong_time,
    output round_active, action, count, level_num, window_start, game_over, win
  );

  modport slave (
    output start, wrong_time,
    input  round_active, action, count, level_num, window_start, game_over, win
  );
endinterface

// File: rtl/ninja_tick_gen.sv
// Game tick divider: one-cycle tick every TICK_DIV enabled cycles, restartable
// through clear so a new phase always begins on a tick boundary.
module ninja_tick_gen #(
  parameter int unsigned TICK_DIV = ninja_pkg::DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam int unsigned   DW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 div <= '0;
    else if (clear || !en)   div <= '0;
    else if (div == LAST)    div <= '0;
    else                     div <= div + 1'b1;
  end

  assign tick = en && (div == LAST);
endmodule

// File: rtl/ninja_action_gen.sv
// Prompt side of the reflex game: sequences gap/answer-window rounds, draws
// the action from a free-running LFSR and ends the game on win or loss.
module ninja_action_gen
  import ninja_pkg::*;
#(
  parameter int unsigned TICK_DIV         = DEF_TICK_DIV,
  parameter int unsigned WINDOW_TICKS     = 50,
  parameter int unsigned WINDOW_STEP      = 10,
  parameter int unsigned WINDOW_MIN       = 10,
  parameter int unsigned GAP_TICKS        = 10,
  parameter int unsigned ROUNDS_PER_LEVEL = 8,
  parameter int unsigned MAX_LEVEL        = 4,
  parameter int unsigned MAX_WRONG        = 10,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input logic                clk,
  input logic                rst,
  ninja_action_gen_if.master bus
);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_TICKS - 1);
  localparam logic [7:0] ROUND_LAST  = 8'(ROUNDS_PER_LEVEL - 1);
  localparam logic [2:0] LEVEL_TOP   = 3'(MAX_LEVEL);
  localparam logic [7:0] WRONG_LIMIT = 8'(MAX_WRONG);

  state_t      state, state_d;
  logic [7:0]  tick_cnt, tick_cnt_d;
  logic [7:0]  round_cnt, round_cnt_d;
  logic [15:0] lfsr;
  action_t     action, action_d;
  logic [7:0]  count, count_d;
  logic [2:0]  level_num, level_d;
  logic        win, win_d;
  logic        round_active, window_start, game_over;
  logic        tick, tick_en, clear, lost;
  logic [7:0]  window_last;

  assign tick_en     = (state != IDLE);
  assign clear       = (state_d != state);
  assign lost        = (bus.wrong_time >= WRONG_LIMIT);
  assign window_last = window_len(level_num, 8'(WINDOW_TICKS), 8'(WINDOW_STEP),
                                  8'(WINDOW_MIN)) - 8'd1;

  ninja_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (tick_en),
    .tick  (tick)
  );

  // NOTE: every variable written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    tick_cnt_d  = tick_cnt;
    round_cnt_d = round_cnt;
    action_d    = action;
    count_d     = count;
    level_d     = level_num;
    win_d       = win;

    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = GAP;
          count_d     = 8'd0;
          level_d     = 3'd0;
          win_d       = 1'b0;
          round_cnt_d = 8'd0;
        end
      end
      GAP: begin
        if (lost) begin
          state_d = DONE;
          win_d   = 1'b0;
        end else if (tick) begin
          if (tick_cnt == GAP_LAST) begin
            state_d  = SHOW;
            action_d = {2'b00, lfsr[1:0]};
          end else begin
            tick_cnt_d = tick_cnt + 8'd1;
          end
        end
      end
      SHOW: begin
        // Loss is checked first: an expiring window never scores after a loss.
        if (lost) begin
          state_d = DONE;
          win_d   = 1'b0;
        end else if (tick) begin
          if (tick_cnt == window_last) begin
            count_d = (count == 8'hFF) ? count : count + 8'd1;
            state_d = GAP;
            if (round_cnt == ROUND_LAST) begin
              round_cnt_d = 8'd0;
              if (level_num == LEVEL_TOP) begin
                state_d = DONE;
                win_d   = 1'b1;
              end else begin
                level_d = level_num + 3'd1;
              end
            end else begin
              round_cnt_d = round_cnt + 8'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state) tick_cnt_d = 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tick_cnt     <= 8'd0;
      round_cnt    <= 8'd0;
      lfsr         <= LFSR_SEED;
      action       <= '0;
      count        <= 8'd0;
      level_num    <= 3'd0;
      win          <= 1'b0;
      round_active <= 1'b0;
      window_start <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_d;
      tick_cnt     <= tick_cnt_d;
      round_cnt    <= round_cnt_d;
      lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      action       <= action_d;
      count        <= count_d;
      level_num    <= level_d;
      win          <= win_d;
      // Status flags are derived from the next state so they move with it.
      round_active <= (state_d == SHOW);
      window_start <= (state == GAP) && (state_d == SHOW);
      game_over    <= (state_d == DONE);
    end
  end

  assign bus.round_active = round_active;
  assign bus.action       = action;
  assign bus.count        = count;
  assign bus.level_num    = level_num;
  assign bus.window_start = window_start;
  assign bus.game_over    = game_over;
  assign bus.win          = win;
endmodule

// File: tb/tb_ninja_action_gen.sv
// Bench for ninja_action_gen: a cycle-level game model checks every output each
// cycle, plus end-of-game vector table, timing sequences and a clamp/saturation run.
module tb_ninja_action_gen;
  localparam int TD = 4, GT = 2, WT = 5, WS = 1, WM = 2, RPL = 2, ML = 1, MW = 3;
  localparam int WT2 = 5, WS2 = 20, WM2 = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ninja_action_gen_if bus ();
  ninja_action_gen_if bus2 ();

  ninja_action_gen #(
    .TICK_DIV(TD), .WINDOW_TICKS(WT), .WINDOW_STEP(WS), .WINDOW_MIN(WM), .GAP_TICKS(GT),
    .ROUNDS_PER_LEVEL(RPL), .MAX_LEVEL(ML), .MAX_WRONG(MW), .LFSR_SEED(SEED)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  ninja_action_gen #(
    .TICK_DIV(1), .WINDOW_TICKS(WT2), .WINDOW_STEP(WS2), .WINDOW_MIN(WM2), .GAP_TICKS(1),
    .ROUNDS_PER_LEVEL(100), .MAX_LEVEL(3), .MAX_WRONG(3), .LFSR_SEED(SEED)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Game model in whole clock cycles: phase 0 idle, 1 gap, 2 window, 3 over.
  int          m_ph, m_left, m_round;
  logic [7:0]  m_count;
  logic [2:0]  m_level;
  logic [3:0]  m_action;
  logic        m_ws, m_win;
  logic [15:0] m_lfsr;

  function automatic int window_cycles(input int lvl);
    int w;
    w = WT - lvl * WS;
    if (w < WM) w = WM;
    return w * TD;
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_left = 0; m_round = 0; m_count = 0; m_level = 0;
    m_action = 0; m_ws = 0; m_win = 0; m_lfsr = SEED;
  endfunction

  function automatic void new_gap();
    m_ph = 1;
    m_left = GT * TD;
  endfunction

  function automatic void model_edge();
    logic [15:0] l;
    l = m_lfsr;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    m_ws = 0;
    if (m_ph == 0 || m_ph == 3) begin
      if (bus.start) begin
        new_gap();
        m_count = 0; m_level = 0; m_win = 0; m_round = 0;
      end
    end else if (int'(bus.wrong_time) >= MW) begin
      m_ph = 3;
      m_win = 0;
    end else begin
      m_left -= 1;
      if (m_left == 0 && m_ph == 1) begin
        m_ph = 2;
        m_left = window_cycles(int'(m_level));
        m_action = {2'b00, l[1:0]};
        m_ws = 1;
      end else if (m_left == 0) begin
        if (m_count != 8'd255) m_count += 1;
        if (m_round == RPL - 1 && int'(m_level) == ML) begin
          m_ph = 3;
          m_win = 1;
        end else if (m_round == RPL - 1) begin
          m_round = 0;
          m_level += 1;
          new_gap();
        end else begin
          m_round += 1;
          new_gap();
        end
      end
    end
  endfunction

  function automatic logic [31:0] dut_vec();
    return {13'b0, bus.round_active, bus.action, bus.count, bus.level_num,
            bus.window_start, bus.game_over, bus.win};
  endfunction

  function automatic logic [31:0] model_vec();
    return {13'b0, m_ph == 2, m_action, m_count, m_level, m_ws, m_ph == 3, m_win};
  endfunction

  task automatic step_cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(tag, dut_vec(), model_vec());
  endtask

  // Starts a game and plays it out; wrong_time jumps to wval from edge loss_edge on.
  task automatic run_game(input string tag, input int loss_edge, input logic [7:0] wval,
                          input bit noise);
    int n;
    bus.start = 1'b1;
    step_cycle(tag);
    bus.start = 1'b0;
    n = 1;
    while (!bus.game_over && n < 400) begin
      if (loss_edge > 0 && n >= loss_edge) bus.wrong_time = wval;
      else bus.wrong_time = noise ? 8'($urandom_range(0, MW - 1)) : 8'd0;
      bus.start = noise && ($urandom_range(0, 15) == 0);
      step_cycle(tag);
      n++;
    end
    check({tag, "_ended"}, bus.game_over, 1'b1);
    bus.start = 1'b0;
    bus.wrong_time = 8'd0;
  endtask

  typedef struct {
    int         loss_edge;
    logic [7:0] wval;
    logic       exp_win;
    logic [7:0] exp_count;
    logic [2:0] exp_level;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, len, rounds, lvl, w;
    int wins[$];

    // Edges after the start edge: windows end at 28, 56, 80, 104.
    vecs[0] = '{-1,  8'd0,   1'b1, 8'd4, 3'd1};
    vecs[1] = '{5,   8'd3,   1'b0, 8'd0, 3'd0};
    vecs[2] = '{15,  8'd3,   1'b0, 8'd0, 3'd0};
    vecs[3] = '{28,  8'd3,   1'b0, 8'd0, 3'd0};
    vecs[4] = '{29,  8'd4,   1'b0, 8'd1, 3'd0};
    vecs[5] = '{56,  8'd3,   1'b0, 8'd1, 3'd0};
    vecs[6] = '{57,  8'd3,   1'b0, 8'd2, 3'd1};
    vecs[7] = '{103, 8'd3,   1'b0, 8'd3, 3'd1};
    vecs[8] = '{104, 8'd200, 1'b0, 8'd3, 3'd1};

    bus.start = 1'b0; bus.wrong_time = 8'd0;
    bus2.start = 1'b0; bus2.wrong_time = 8'd0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset", dut_vec(), 32'd0);

    // Gap of 8 cycles, single-cycle window_start, 20-cycle window.
    repeat (3) step_cycle("idle");
    bus.start = 1'b1;
    step_cycle("t1");
    bus.start = 1'b0;
    n = 0;
    while (!bus.window_start && n < 50) begin
      step_cycle("t1");
      n++;
    end
    check("t1_gap_len", n, 8);
    check("t1_action", bus.action, m_action);
    len = 0;
    while (bus.round_active && len < 100) begin
      len++;
      step_cycle("t1");
      if (len == 1) check("t1_ws_pulse", bus.window_start, 1'b0);
    end
    check("t1_window_len", len, 20);
    n = 0;
    while (!bus.game_over && n < 200) begin
      step_cycle("t1");
      n++;
    end

    // Full winning game: window lengths per round and final status.
    len = 0; n = 0;
    bus.start = 1'b1;
    step_cycle("t2");
    bus.start = 1'b0;
    while (!bus.game_over && n < 300) begin
      if (bus.round_active) len++;
      else if (len > 0) begin
        wins.push_back(len);
        len = 0;
      end
      step_cycle("t2");
      n++;
    end
    if (len > 0) wins.push_back(len);
    check("t2_rounds", wins.size(), 4);
    for (int i = 0; i < 4 && i < wins.size(); i++)
      check($sformatf("t2_window%0d", i), wins[i], (i < 2) ? 20 : 16);
    check("t2_win", bus.win, 1'b1);
    check("t2_count", bus.count, 8'd4);
    check("t2_level", bus.level_num, 3'd1);

    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(0, 4)) step_cycle("idle");
      run_game($sformatf("vec%0d", i), vecs[i].loss_edge, vecs[i].wval, 1'b0);
      check($sformatf("vec%0d_win", i), bus.win, vecs[i].exp_win);
      check($sformatf("vec%0d_count", i), bus.count, vecs[i].exp_count);
      check($sformatf("vec%0d_level", i), bus.level_num, vecs[i].exp_level);
      check($sformatf("vec%0d_round_active", i), bus.round_active, 1'b0);
    end

    for (int g = 0; g < 20; g++) begin
      repeat ($urandom_range(0, 7)) step_cycle("idle");
      run_game($sformatf("rnd%0d", g), $urandom_range(1, 130),
               8'($urandom_range(MW, 255)), 1'b1);
    end

    // Asynchronous reset in the middle of a window, then a clean restart.
    bus.start = 1'b1;
    step_cycle("t5");
    bus.start = 1'b0;
    n = 0;
    while (!bus.round_active && n < 50) begin
      step_cycle("t5");
      n++;
    end
    repeat (3) step_cycle("t5");
    #2 rst = 1'b1;
    #1 check("t5_async_reset", dut_vec(), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_game("t5_restart", -1, 8'd0, 1'b0);
    check("t5_restart_win", bus.win, 1'b1);

    // Large window step: windows clamp to the floor, count saturates at 255.
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    rounds = 0; len = 0; lvl = 0;
    for (int c = 0; c < 3000; c++) begin
      if (bus2.window_start) lvl = int'(bus2.level_num);
      if (bus2.round_active) len++;
      else if (len > 0) begin
        w = WT2 - lvl * WS2;
        if (w < WM2) w = WM2;
        check($sformatf("t6_window_r%0d", rounds), len, w);
        rounds++;
        check($sformatf("t6_count_r%0d", rounds), bus2.count, (rounds > 255) ? 255 : rounds);
        len = 0;
      end
      if (bus2.game_over) break;
      @(negedge clk);
    end
    check("t6_rounds", rounds, 400);
    check("t6_game_over", bus2.game_over, 1'b1);
    check("t6_win", bus2.win, 1'b1);
    check("t6_count_sat", bus2.count, 8'd255);
    check("t6_level", bus2.level_num, 3'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
